// File: rtl/alu_cmd_initiator.sv
// Command initiator sitting between an upstream command stream and a
// start/done ALU: issues one operation at a time and returns a response.
module alu_cmd_initiator #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [2:0]  cmd_op,
  output logic [7:0]  A,
  output logic [7:0]  B,
  output logic [2:0]  op_code,
  output logic        start,
  input  logic        done,
  input  logic [15:0] result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [2:0]  rsp_op,
  output logic        rsp_error,
  output logic [15:0] ops_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, GAP} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic [7:0] timeout_cnt;
  logic       op_legal;

  assign op_legal = (cmd_op == 3'b001) || (cmd_op == 3'b010) || (cmd_op == 3'b011);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      start       <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_error   <= 1'b0;
      A           <= 8'h00;
      B           <= 8'h00;
      op_code     <= 3'b000;
      rsp_result  <= 16'h0000;
      rsp_op      <= 3'b000;
      ops_done    <= 16'h0000;
      timeout_cnt <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            if (op_legal) begin
              A           <= cmd_a;
              B           <= cmd_b;
              op_code     <= cmd_op;
              start       <= 1'b1;
              timeout_cnt <= 8'h00;
              state       <= ISSUE;
            end else begin
              rsp_result <= 16'h0000;
              rsp_op     <= cmd_op;
              rsp_error  <= 1'b1;
              rsp_valid  <= 1'b1;
              state      <= RESP;
            end
          end
        end

        // done is tested first so a completion on the final timeout cycle wins.
        ISSUE: begin
          timeout_cnt <= timeout_cnt + 8'd1;
          if (done) begin
            start      <= 1'b0;
            rsp_result <= result;
            rsp_op     <= op_code;
            rsp_error  <= 1'b0;
            rsp_valid  <= 1'b1;
            ops_done   <= ops_done + 16'd1;
            state      <= RESP;
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            start      <= 1'b0;
            rsp_result <= 16'h0000;
            rsp_op     <= op_code;
            rsp_error  <= 1'b1;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= GAP;
          end
        end

        // One dead cycle lets the ALU's start pipeline drain before the next command.
        GAP: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_initiator.sv
// Self-checking bench for alu_cmd_initiator: directed table, random commands
// against a transaction-level model, and reset / spurious-done sequences.
module tb_alu_cmd_initiator;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_a = 8'h00;
  logic [7:0]  cmd_b = 8'h00;
  logic [2:0]  cmd_op = 3'b000;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [2:0]  op_code;
  logic        start;
  logic        done;
  logic [15:0] result = 16'h0000;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_error;
  logic [15:0] ops_done;

  int          vec_count = 0;
  int          miscompares = 0;
  logic [15:0] ops_model = 16'h0000;

  int   alu_lat = 0;
  int   alu_cnt = 0;
  logic alu_done = 1'b0;
  logic spur_done = 1'b0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  op;
    int          lat;
    int          hold;
    logic [15:0] res;
    logic        err;
    int          lat_exp;
  } vec_t;

  vec_t tbl[11];

  alu_cmd_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .A(A), .B(B), .op_code(op_code), .start(start),
    .done(done), .result(result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_error(rsp_error),
    .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
    case (op)
      3'd1:    return {8'h00, a} + {8'h00, b};
      3'd2:    return {8'h00, a & b};
      3'd3:    return {8'h00, a ^ b};
      default: return 16'h0000;
    endcase
  endfunction

  // ALU model: done pulses alu_lat edges after start rises (alu_lat=0: never).
  always @(posedge clk) begin
    if (!start) alu_cnt <= 0;
    else        alu_cnt <= alu_cnt + 1;
    alu_done <= (alu_lat > 0) && start && (alu_cnt == alu_lat - 1);
    result   <= alu_ref(A, B, op_code);
  end

  assign done = alu_done | spur_done;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    vec_count++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                               input int lat, input int hold, input logic [15:0] exp_res,
                               input logic exp_err, input int exp_lat, input string tag);
    int          n;
    int          waited;
    logic        bad;
    logic [15:0] exp_ops;
    logic [15:0] r_res;
    logic [2:0]  r_op;
    logic        r_err;
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, ".ready"}, 32'(cmd_ready), 32'd1);
    exp_ops   = ops_model + (exp_err ? 16'd0 : 16'd1);
    alu_lat   = lat;
    rsp_ready = (hold == 0);
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    @(negedge clk);
    cmd_valid = 1'b0;
    n   = 0;
    bad = 1'b0;
    while (rsp_valid !== 1'b1 && n < 300) begin
      if (start !== 1'b1 || A !== a || B !== b || op_code !== op) bad = 1'b1;
      @(negedge clk);
      n++;
    end
    checkOutput({tag, ".issue_stable"}, 32'(bad), 32'd0);
    checkOutput({tag, ".latency"}, 32'(n), 32'(exp_lat));
    checkOutput({tag, ".start_off"}, 32'(start), 32'd0);
    checkOutput({tag, ".rsp_result"}, 32'(rsp_result), 32'(exp_res));
    checkOutput({tag, ".rsp_error"}, 32'(rsp_error), 32'(exp_err));
    checkOutput({tag, ".rsp_op"}, 32'(rsp_op), 32'(op));
    checkOutput({tag, ".ops_done"}, 32'(ops_done), 32'(exp_ops));
    ops_model = exp_ops;
    r_res = rsp_result;
    r_op  = rsp_op;
    r_err = rsp_error;
    bad   = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_result !== r_res || rsp_op !== r_op ||
          rsp_error !== r_err || cmd_ready !== 1'b0 || start !== 1'b0) bad = 1'b1;
    end
    if (hold > 0) checkOutput({tag, ".backpressure"}, 32'(bad), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput({tag, ".gap_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, ".gap_ready"}, 32'(cmd_ready), 32'd0);
    checkOutput({tag, ".gap_start"}, 32'(start), 32'd0);
    @(negedge clk);
    checkOutput({tag, ".idle_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [2:0]  rop;
    int          rlat;
    int          rhold;
    logic        legal;
    logic        ok;

    tbl[0]  = '{8'hFF, 8'h01, 3'b001,  2, 0, 16'h0100, 1'b0,  3};
    tbl[1]  = '{8'hA5, 8'h0F, 3'b011,  2, 0, 16'h00AA, 1'b0,  3};
    tbl[2]  = '{8'hF0, 8'h3C, 3'b010,  2, 0, 16'h0030, 1'b0,  3};
    tbl[3]  = '{8'h12, 8'h34, 3'b111,  2, 0, 16'h0000, 1'b1,  0};
    tbl[4]  = '{8'h55, 8'h66, 3'b000,  2, 0, 16'h0000, 1'b1,  0};
    tbl[5]  = '{8'h80, 8'h80, 3'b001,  1, 5, 16'h0100, 1'b0,  2};
    tbl[6]  = '{8'h12, 8'h34, 3'b011,  0, 0, 16'h0000, 1'b1, 15};
    tbl[7]  = '{8'hFF, 8'hFF, 3'b010, 14, 0, 16'h00FF, 1'b0, 15};
    tbl[8]  = '{8'h01, 8'h02, 3'b001, 15, 0, 16'h0000, 1'b1, 15};
    tbl[9]  = '{8'h9A, 8'hBC, 3'b100,  3, 2, 16'h0000, 1'b1,  0};
    tbl[10] = '{8'h7F, 8'h01, 3'b110,  3, 0, 16'h0000, 1'b1,  0};

    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset.start", 32'(start), 32'd0);
    checkOutput("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset.rsp_error", 32'(rsp_error), 32'd0);
    checkOutput("reset.ops_done", 32'(ops_done), 32'd0);
    checkOutput("reset.rsp_result", 32'(rsp_result), 32'd0);
    checkOutput("reset.A", 32'(A), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset.cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].lat, tbl[i].hold,
                    tbl[i].res, tbl[i].err, tbl[i].lat_exp, $sformatf("tbl%0d", i));
    end

    // A stray done while idle must not move the block or its counter.
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    checkOutput("spur.cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("spur.rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("spur.ops_done", 32'(ops_done), 32'(ops_model));

    for (int i = 0; i < 40; i++) begin
      ra    = 8'($urandom);
      rb    = 8'($urandom);
      rop   = 3'($urandom_range(0, 7));
      rlat  = $urandom_range(0, 17);
      rhold = $urandom_range(0, 3);
      legal = (rop >= 3'd1) && (rop <= 3'd3);
      ok    = legal && (rlat > 0) && (rlat + 1 <= TO);
      applyStimulus(ra, rb, rop, rlat, rhold,
                    ok ? alu_ref(ra, rb, rop) : 16'h0000, !ok,
                    !legal ? 0 : (ok ? rlat + 1 : TO), $sformatf("rnd%0d", i));
    end

    // Reset while a command is outstanding.
    alu_lat   = 0;
    cmd_valid = 1'b1;
    cmd_a     = 8'h03;
    cmd_b     = 8'h04;
    cmd_op    = 3'b001;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("midreset.start_before", 32'(start), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checkOutput("midreset.start", 32'(start), 32'd0);
    checkOutput("midreset.ops_done", 32'(ops_done), 32'd0);
    checkOutput("midreset.rsp_valid", 32'(rsp_valid), 32'd0);
    ops_model = 16'h0000;
    @(negedge clk);
    checkOutput("midreset.cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("midreset.start_after", 32'(start), 32'd0);
    applyStimulus(8'h10, 8'h20, 3'b001, 2, 0, 16'h0030, 1'b0, 3, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
